// File: rtl/cv32e40px_core_v_xif_pkg.sv
// CORE-V-XIF types shared between the core and the offload logic.
// Only the commit packet is needed by the ID tracker.
package cv32e40px_core_v_xif_pkg;

    localparam int unsigned X_ID_WIDTH = 4;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  commit_kill;
    } x_commit_t;

endpackage

// File: rtl/cv32e40px_x_tracker_pkg.sv
// Types for the XIF outstanding-transaction tracker.
// Entry lifecycle states; FREE must stay the reset encoding.
package cv32e40px_x_tracker_pkg;

    typedef enum logic [1:0] {
        X_FREE      = 2'd0,
        X_ISSUED    = 2'd1,
        X_COMMITTED = 2'd2
    } x_trk_state_e;

endpackage

// File: rtl/cv32e40px_x_id_tracker_entry.sv
// One tracker entry: lifecycle FSM, id/writeback registers, CAM match outputs.
// Latency: matches are combinational on registered state, updates land at the next edge.
// Backpressure: none; the enables are qualified by the owner.
module cv32e40px_x_id_tracker_entry
    import cv32e40px_x_tracker_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_en,
    input  logic [X_ID_WIDTH-1:0] alloc_id,
    input  logic                  alloc_wb,
    input  logic                  commit_en,
    input  logic                  commit_kill,
    input  logic                  result_en,
    input  logic [X_ID_WIDTH-1:0] commit_id,
    input  logic [X_ID_WIDTH-1:0] result_id,
    output x_trk_state_e          state,
    output logic [X_ID_WIDTH-1:0] id,
    output logic                  wb,
    output logic                  commit_match,
    output logic                  result_match
);

    x_trk_state_e          state_q, state_d;
    logic [X_ID_WIDTH-1:0] id_q;
    logic                  wb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= X_FREE;
            id_q    <= '0;
            wb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (alloc_en) begin
                id_q <= alloc_id;
                wb_q <= alloc_wb;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            X_FREE:      if (alloc_en) state_d = X_ISSUED;
            // A committed instruction only lingers if a result is still owed.
            X_ISSUED:    if (commit_en) state_d = (!commit_kill && wb_q) ? X_COMMITTED : X_FREE;
            X_COMMITTED: if (result_en) state_d = X_FREE;
            default:     state_d = X_FREE;
        endcase
    end

    assign commit_match = (state_q == X_ISSUED)    && (id_q == commit_id);
    assign result_match = (state_q == X_COMMITTED) && (id_q == result_id);
    assign state        = state_q;
    assign id           = id_q;
    assign wb           = wb_q;

endmodule

// File: rtl/cv32e40px_x_id_tracker.sv
// Tracks outstanding XIF offloads: hands out IDs, follows commit/result, retires entries.
// Latency: commit/result lookups are 0-cycle CAMs, state updates at the next clk_i edge.
// Backpressure: id_avail_o drops when full or next ID live; CV32E40PX_X_TRACKER_TIMEOUT_EN adds a watchdog.
module cv32e40px_x_id_tracker
    import cv32e40px_core_v_xif_pkg::x_commit_t;
    import cv32e40px_x_tracker_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH     = 4,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic [X_ID_WIDTH-1:0]      next_id_o,
    output logic                       id_avail_o,
    input  logic                       alloc_i,
    input  logic                       alloc_wb_i,
    input  logic                       commit_valid_i,
    input  x_commit_t                  commit_i,
    input  logic                       result_valid_i,
    input  logic [X_ID_WIDTH-1:0]      result_id_i,
    output logic                       result_ready_o,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       err_o,
    output logic                       timeout_o
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    x_trk_state_e                         ent_state [DEPTH];
    logic [DEPTH-1:0][X_ID_WIDTH-1:0]     ent_id;
    logic [DEPTH-1:0]                     ent_wb, ent_cm, ent_rm;
    logic [DEPTH-1:0]                     alloc_sel, commit_hit, result_hit;
    logic [X_ID_WIDTH-1:0]                next_id_q, commit_id;
    logic [CW-1:0]                        outstanding_q;
    logic                                 err_q, id_in_use, alloc_ok, found;
    logic                                 commit_any, commit_retire, result_any;

    assign commit_id = X_ID_WIDTH'(commit_i.id);

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        cv32e40px_x_id_tracker_entry #(.X_ID_WIDTH(X_ID_WIDTH)) u_entry (
            .clk          (clk_i),
            .rst          (rst_i),
            .alloc_en     (alloc_ok && alloc_sel[g]),
            .alloc_id     (next_id_q),
            .alloc_wb     (alloc_wb_i),
            .commit_en    (commit_hit[g]),
            .commit_kill  (commit_i.commit_kill),
            .result_en    (result_hit[g]),
            .commit_id    (commit_id),
            .result_id    (result_id_i),
            .state        (ent_state[g]),
            .id           (ent_id[g]),
            .wb           (ent_wb[g]),
            .commit_match (ent_cm[g]),
            .result_match (ent_rm[g])
        );
    end

    // Lowest-index free entry wins; id uniqueness among live entries is what keeps the CAMs one-hot.
    always_comb begin
        alloc_sel = '0;
        found     = 1'b0;
        id_in_use = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && ent_state[i] == X_FREE) begin
                alloc_sel[i] = 1'b1;
                found        = 1'b1;
            end
            if (ent_state[i] != X_FREE && ent_id[i] == next_id_q) id_in_use = 1'b1;
        end
    end

    assign full_o        = (outstanding_q == CW'(DEPTH));
    assign empty_o       = (outstanding_q == '0);
    assign id_avail_o    = !full_o && !id_in_use;
    assign alloc_ok      = alloc_i && id_avail_o;
    assign commit_hit    = commit_valid_i ? ent_cm : '0;
    assign result_hit    = result_valid_i ? ent_rm : '0;
    assign commit_any    = |commit_hit;
    assign result_any    = |result_hit;
    assign commit_retire = commit_any && (commit_i.commit_kill || !(|(commit_hit & ent_wb)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            next_id_q     <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            if (alloc_ok) next_id_q <= next_id_q + X_ID_WIDTH'(1);
            outstanding_q <= outstanding_q + CW'(alloc_ok) - CW'(commit_retire) - CW'(result_any);
            if ((alloc_i && !id_avail_o) || (commit_valid_i && !commit_any) ||
                (result_valid_i && !result_any))
                err_q <= 1'b1;
        end
    end

    assign next_id_o      = next_id_q;
    assign outstanding_o  = outstanding_q;
    assign err_o          = err_q;
    assign result_ready_o = !rst_i;

`ifdef CV32E40PX_X_TRACKER_TIMEOUT_EN
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES+1);

    logic [IW-1:0]         oldest_idx, oldest_idx_q;
    logic [X_ID_WIDTH-1:0] age, oldest_age;
    logic [TW-1:0]         to_cnt_q;
    logic                  any_live, timeout_q;

    // IDs are handed out in order and never reused while live, so distance behind next_id is age.
    always_comb begin
        any_live   = 1'b0;
        oldest_idx = '0;
        oldest_age = '0;
        age        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age = next_id_q - ent_id[i] - X_ID_WIDTH'(1);
            if (ent_state[i] != X_FREE && (!any_live || age > oldest_age)) begin
                any_live   = 1'b1;
                oldest_idx = IW'(i);
                oldest_age = age;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            oldest_idx_q <= '0;
            to_cnt_q     <= '0;
            timeout_q    <= 1'b0;
        end else begin
            oldest_idx_q <= oldest_idx;
            if (!any_live || oldest_idx != oldest_idx_q) begin
                to_cnt_q <= '0;
            end else begin
                if (to_cnt_q != TW'(TIMEOUT_CYCLES)) to_cnt_q <= to_cnt_q + TW'(1);
                if (to_cnt_q >= TW'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40px_x_id_tracker.sv
// Directed bench for the XIF ID tracker: vector table plus multi-cycle corner sequences.
module tb_cv32e40px_x_id_tracker;
    import cv32e40px_core_v_xif_pkg::x_commit_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] next_id_o;
    logic       id_avail_o;
    logic       alloc_i = 1'b0, alloc_wb_i = 1'b0;
    logic       commit_valid_i = 1'b0;
    x_commit_t  commit_i = '0;
    logic       result_valid_i = 1'b0;
    logic [3:0] result_id_i = '0;
    logic       result_ready_o;
    logic [2:0] outstanding_o;
    logic       empty_o, full_o, err_o, timeout_o;

    int checks = 0;
    int errors = 0;

    cv32e40px_x_id_tracker #(.X_ID_WIDTH(4), .DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .next_id_o      (next_id_o),
        .id_avail_o     (id_avail_o),
        .alloc_i        (alloc_i),
        .alloc_wb_i     (alloc_wb_i),
        .commit_valid_i (commit_valid_i),
        .commit_i       (commit_i),
        .result_valid_i (result_valid_i),
        .result_id_i    (result_id_i),
        .result_ready_o (result_ready_o),
        .outstanding_o  (outstanding_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .err_o          (err_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       alloc, wb, cv;
        logic [3:0] cid;
        logic       kill, rv;
        logic [3:0] rid;
        logic [3:0] e_next;
        logic       e_avail;
        logic [2:0] e_out;
        logic       e_full, e_empty, e_err;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, let it land on the edge, then idle the inputs.
    task automatic cyc(input logic a, input logic w, input logic cv, input logic [3:0] cid,
                       input logic k, input logic rv, input logic [3:0] rid);
        alloc_i = a; alloc_wb_i = w;
        commit_valid_i = cv; commit_i.id = cid; commit_i.commit_kill = k;
        result_valid_i = rv; result_id_i = rid;
        @(posedge clk_i);
        #1;
        alloc_i = 1'b0; alloc_wb_i = 1'b0; commit_valid_i = 1'b0; result_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        alloc_i = 1'b0; commit_valid_i = 1'b0; result_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_result_ready", int'(result_ready_o), 0);
        chk("rst_next_id",      int'(next_id_o),      0);
        chk("rst_id_avail",     int'(id_avail_o),     1);
        chk("rst_outstanding",  int'(outstanding_o),  0);
        chk("rst_empty",        int'(empty_o),        1);
        chk("rst_full",         int'(full_o),         0);
        chk("rst_err",          int'(err_o),          0);
        chk("rst_timeout",      int'(timeout_o),      0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_result_ready", int'(result_ready_o), 1);
    endtask

    function automatic vec_t mk(input logic a, w, cv, input logic [3:0] cid, input logic k, rv,
                                input logic [3:0] rid, input logic [3:0] nx, input logic av,
                                input logic [2:0] o, input logic f, em, er);
        vec_t v;
        v.alloc = a; v.wb = w; v.cv = cv; v.cid = cid; v.kill = k; v.rv = rv; v.rid = rid;
        v.e_next = nx; v.e_avail = av; v.e_out = o; v.e_full = f; v.e_empty = em; v.e_err = er;
        return v;
    endfunction

    vec_t vecs [19];

    initial begin
        //             a  w  cv cid k  rv rid  next av out f  e  err
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 0, 0,   2, 1, 2, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 0, 0, 0,   3, 1, 3, 0, 0, 0);
        vecs[3]  = mk(1, 1, 0, 0, 0, 0, 0,   4, 0, 4, 1, 0, 0);
        vecs[4]  = mk(0, 0, 1, 1, 1, 0, 0,   4, 1, 3, 0, 0, 0);
        vecs[5]  = mk(0, 0, 1, 2, 0, 0, 0,   4, 1, 3, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 1, 2,   4, 1, 2, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 1, 3,   4, 1, 2, 0, 0, 1);
        vecs[8]  = mk(0, 0, 1, 3, 0, 0, 0,   4, 1, 2, 0, 0, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 1, 3,   4, 1, 1, 0, 0, 1);
        vecs[10] = mk(1, 0, 0, 0, 0, 0, 0,   5, 1, 2, 0, 0, 1);
        vecs[11] = mk(1, 0, 0, 0, 0, 0, 0,   6, 1, 3, 0, 0, 1);
        vecs[12] = mk(1, 0, 1, 4, 0, 0, 0,   7, 1, 3, 0, 0, 1);
        vecs[13] = mk(1, 1, 0, 0, 0, 0, 0,   8, 0, 4, 1, 0, 1);
        vecs[14] = mk(0, 0, 1, 0, 1, 0, 0,   8, 1, 3, 0, 0, 1);
        vecs[15] = mk(0, 0, 1, 5, 0, 0, 0,   8, 1, 2, 0, 0, 1);
        vecs[16] = mk(0, 0, 1, 6, 1, 0, 0,   8, 1, 1, 0, 0, 1);
        vecs[17] = mk(0, 0, 1, 7, 0, 0, 0,   8, 1, 1, 0, 0, 1);
        vecs[18] = mk(0, 0, 0, 0, 0, 1, 7,   8, 1, 0, 0, 1, 1);

        do_reset();
        for (int i = 0; i < 19; i++) begin
            cyc(vecs[i].alloc, vecs[i].wb, vecs[i].cv, vecs[i].cid, vecs[i].kill,
                vecs[i].rv, vecs[i].rid);
            chk($sformatf("v%0d_next_id", i),     int'(next_id_o),     int'(vecs[i].e_next));
            chk($sformatf("v%0d_id_avail", i),    int'(id_avail_o),    int'(vecs[i].e_avail));
            chk($sformatf("v%0d_outstanding", i), int'(outstanding_o), int'(vecs[i].e_out));
            chk($sformatf("v%0d_full", i),        int'(full_o),        int'(vecs[i].e_full));
            chk($sformatf("v%0d_empty", i),       int'(empty_o),       int'(vecs[i].e_empty));
            chk($sformatf("v%0d_err", i),         int'(err_o),         int'(vecs[i].e_err));
        end

        // Result in the same cycle as its commit is too early.
        do_reset();
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 1, 0);
        chk("same_cycle_result_err", int'(err_o),         1);
        chk("same_cycle_result_out", int'(outstanding_o), 1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("late_result_out", int'(outstanding_o), 0);

        // Commit to an id that was never issued.
        do_reset();
        cyc(0, 0, 1, 9, 0, 0, 0);
        chk("unknown_commit_err", int'(err_o),         1);
        chk("unknown_commit_out", int'(outstanding_o), 0);

        // Alloc while full is dropped; then reset mid-operation clears everything.
        do_reset();
        repeat (4) cyc(1, 1, 0, 0, 0, 0, 0);
        chk("fill_err", int'(err_o), 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("full_alloc_err",  int'(err_o),         1);
        chk("full_alloc_next", int'(next_id_o),     4);
        chk("full_alloc_out",  int'(outstanding_o), 4);
        do_reset();

        // Live id 0 blocks allocation once next_id wraps back onto it.
        cyc(1, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k < 16; k++) begin
            cyc(1, 0, 0, 0, 0, 0, 0);
            cyc(0, 0, 1, 4'(k), 1, 0, 0);
        end
        chk("blocked_next",  int'(next_id_o),     0);
        chk("blocked_avail", int'(id_avail_o),    0);
        chk("blocked_out",   int'(outstanding_o), 1);
        chk("blocked_err",   int'(err_o),         0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("blocked_alloc_out",  int'(outstanding_o), 1);
        chk("blocked_alloc_next", int'(next_id_o),     0);
        chk("blocked_alloc_err",  int'(err_o),         1);
        cyc(0, 0, 1, 0, 1, 0, 0);
        chk("unblocked_avail", int'(id_avail_o), 1);

        // Twenty alloc/commit pairs wrapping through 15 -> 0.
        do_reset();
        for (int j = 0; j < 20; j++) begin
            cyc(1, 0, 0, 0, 0, 0, 0);
            chk($sformatf("wrap%0d_next", j), int'(next_id_o),     (j + 1) % 16);
            chk($sformatf("wrap%0d_out1", j), int'(outstanding_o), 1);
            cyc(0, 0, 1, 4'(j % 16), 0, 0, 0);
            chk($sformatf("wrap%0d_out0", j), int'(outstanding_o), 0);
        end
        chk("wrap_err", int'(err_o), 0);

`ifdef CV32E40PX_X_TRACKER_TIMEOUT_EN
        do_reset();
        cyc(1, 1, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("timeout_early", int'(timeout_o), 0);
        repeat (10) @(posedge clk_i);
        #1;
        chk("timeout_set", int'(timeout_o), 1);
`else
        repeat (12) @(posedge clk_i);
        #1;
        chk("timeout_tied_low", int'(timeout_o), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
